// File: rtl/fifo_word_packer.sv
// Packs LANES consecutive FIFO entries into one word on a valid/ready master port.
// A flush emits the partial word with a keep mask and m_last.
module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   out_clk,
  input  logic                   reset,
  input  logic                   fifo_e,
  input  logic [WIDTH-1:0]       fifo_data,
  output logic                   fifo_rd,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep,
  output logic                   m_last
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW:0] LANES_W = (CW + 1)'(LANES);

  // state | meaning: S_FILL collecting lanes | S_HOLD word presented downstream
  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic                   r_pend;
  logic                   r_flush_pend;
  logic [WIDTH*LANES-1:0] r_data;
  logic [LANES-1:0]       r_keep;
  logic                   r_last;

  logic [CW:0]            w_fill;
  logic                   w_word_full;
  logic                   w_service;
  logic                   w_accept;
  logic [LANES-1:0]       w_keep_part;

  assign w_fill      = {1'b0, r_cnt} + {{CW{1'b0}}, r_pend};
  assign w_word_full = (r_state == S_FILL) && r_pend && (w_fill == LANES_W);
  // a pending flush is only serviced once no popped byte is still in flight
  assign w_service   = (r_state == S_FILL) && r_flush_pend && !r_pend;
  assign w_accept    = (r_state == S_HOLD) && m_ready;

  always_comb begin
    w_keep_part = '0;
    for (int k = 0; k < LANES; k++) w_keep_part[k] = (CW'(k) < r_cnt);
  end

  always_ff @(posedge out_clk or negedge reset) begin
    if (!reset) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: if (w_word_full || (w_service && (r_cnt != '0))) w_state_nxt = S_HOLD;
      S_HOLD: if (m_ready) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    fifo_rd    = reset && (r_state == S_FILL) && !fifo_e && !r_flush_pend && (w_fill < LANES_W);
    flush_done = (w_accept && r_last) || (w_service && (r_cnt == '0));
    m_valid    = (r_state == S_HOLD);
    m_data     = r_data;
    m_keep     = r_keep;
    m_last     = r_last;
  end

  always_ff @(posedge out_clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_flush_pend <= 1'b0;
      r_data       <= '0;
      r_keep       <= '0;
      r_last       <= 1'b0;
    end else begin
      r_pend <= fifo_rd;
      // pulses arriving while a flush is being serviced merge into it
      if (w_service || w_word_full) r_flush_pend <= 1'b0;
      else if (flush)               r_flush_pend <= 1'b1;

      if ((r_state == S_FILL) && r_pend) begin
        for (int k = 0; k < LANES; k++)
          if (r_cnt == CW'(k)) r_data[k*WIDTH +: WIDTH] <= fifo_data;
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_word_full) begin
        r_keep <= '1;
        r_last <= r_flush_pend || flush;
      end else if (w_service && (r_cnt != '0)) begin
        r_keep <= w_keep_part;
        r_last <= 1'b1;
      end

      if (w_accept) begin
        r_cnt  <= '0;
        r_data <= '0;
        r_keep <= '0;
        r_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based FIFO model, per-cycle word checker
// against the popped byte stream, directed literal cases and a random phase.
module tb_fifo_word_packer;
  localparam int WIDTH = 8;
  localparam int LANES = 4;

  logic        out_clk = 1'b0;
  logic        reset   = 1'b0;
  logic        fifo_e  = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd;
  logic        flush   = 1'b0;
  logic        flush_done;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  fifo_word_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .out_clk(out_clk), .reset(reset), .fifo_e(fifo_e), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .flush(flush), .flush_done(flush_done), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  always #5 out_clk = ~out_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  popped_q[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_keep[$];
  logic        log_last[$];
  int fd_count = 0;
  int pops = 0;
  int pushed_bytes = 0;
  int emitted_bytes = 0;
  bit rand_mode = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed_bytes++;
    fifo_e = 1'b0;
  endtask

  // One clock: sample the pop request, then update the FIFO model after the edge.
  task automatic step();
    bit pop;
    bit stall;
    @(negedge out_clk);
    pop = reset && fifo_rd && !fifo_e;
    @(posedge out_clk);
    #1;
    if (pop) begin
      fifo_data = fifo_q.pop_front();
      popped_q.push_back(fifo_data);
      pops++;
    end else begin
      fifo_data = 8'($urandom);
    end
    stall = 1'b0;
    if (rand_mode) begin
      if ($urandom_range(0, 99) < 45) push(8'($urandom));
      m_ready = ($urandom_range(0, 99) < 60);
      flush   = ($urandom_range(0, 99) < 4);
      stall   = ($urandom_range(0, 99) < 25);
    end
    fifo_e = (fifo_q.size() == 0) || stall;
  endtask

  task automatic wait_words(input int target, input int budget, input string nm);
    int c = 0;
    while (log_data.size() < target && c < budget) begin
      step();
      c++;
    end
    chk(log_data.size() >= target, nm, 32'(log_data.size()), 32'(target));
  endtask

  task automatic chk_word(input int idx, input logic [31:0] d, input logic [3:0] k,
                          input logic l, input string nm);
    if (idx >= log_data.size()) begin
      chk(1'b0, {nm, "_missing"}, 32'(log_data.size()), 32'(idx + 1));
    end else begin
      chk(log_data[idx] == d, {nm, "_data"}, log_data[idx], d);
      chk(log_keep[idx] == k, {nm, "_keep"}, 32'(log_keep[idx]), 32'(k));
      chk(log_last[idx] == l, {nm, "_last"}, 32'(log_last[idx]), 32'(l));
    end
  endtask

  // Per-cycle checker: every accepted word must consist of exactly the bytes
  // popped since the previous word, in pop order, zero-padded.
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  logic [3:0]  pk = '0;
  int          n;
  logic [31:0] e;

  always @(negedge out_clk) begin
    if (!reset) begin
      pv = 1'b0;
    end else begin
      chk(!(fifo_rd && fifo_e), "rd_when_empty", 32'(fifo_rd), 32'(0));
      chk(!(fifo_rd && m_valid), "rd_in_hold", 32'(fifo_rd), 32'(0));
      if (pv && !pr) begin
        chk(m_valid == 1'b1, "valid_dropped", 32'(m_valid), 32'(1));
        chk(m_data == pd, "hold_data_stable", m_data, pd);
        chk(m_keep == pk, "hold_keep_stable", 32'(m_keep), 32'(pk));
        chk(m_last == pl, "hold_last_stable", 32'(m_last), 32'(pl));
      end
      if (m_valid)
        chk(flush_done == (m_ready && m_last), "flush_done_in_hold", 32'(flush_done),
            32'(m_ready && m_last));
      if (m_valid && m_ready) begin
        n = $countones(m_keep);
        e = '0;
        chk(n >= 1 && m_keep == 4'((1 << n) - 1), "keep_shape", 32'(m_keep), 32'((1 << n) - 1));
        chk(popped_q.size() == n, "pops_per_word", 32'(popped_q.size()), 32'(n));
        for (int k = 0; k < n; k++)
          if (popped_q.size() > 0) e[k*8 +: 8] = popped_q.pop_front();
        popped_q.delete();
        chk(m_data == e, "word_data", m_data, e);
        chk(m_last || n == LANES, "partial_without_last", 32'(m_last), 32'(1));
        log_data.push_back(m_data);
        log_keep.push_back(m_keep);
        log_last.push_back(m_last);
        emitted_bytes += n;
      end
      if (flush_done) fd_count++;
      pv = m_valid; pr = m_ready; pd = m_data; pk = m_keep; pl = m_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fd0, p0, c, pb, eb;
    logic [31:0] snap;

    repeat (3) step();
    chk(m_valid == 1'b0, "reset_valid", 32'(m_valid), 32'(0));
    chk(m_data == 32'h0, "reset_data", m_data, 32'h0);
    chk(m_keep == 4'h0, "reset_keep", 32'(m_keep), 32'(0));
    chk(m_last == 1'b0 && flush_done == 1'b0, "reset_last_fd", 32'({m_last, flush_done}), 32'(0));
    reset = 1'b1;
    repeat (2) step();

    // T2: two full words back to back
    m_ready = 1'b1;
    base = log_data.size();
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_words(base + 2, 40, "t2_words");
    chk_word(base, 32'h04030201, 4'hF, 1'b0, "t2_w0");
    chk_word(base + 1, 32'h08070605, 4'hF, 1'b0, "t2_w1");
    repeat (3) step();

    // T3: partial word closed by a flush
    base = log_data.size();
    fd0 = fd_count;
    push(8'hAA); push(8'hBB); push(8'hCC);
    repeat (6) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_words(base + 1, 20, "t3_word");
    step();
    chk_word(base, 32'h00CCBBAA, 4'h7, 1'b1, "t3");
    chk(fd_count == fd0 + 1, "t3_flush_done", 32'(fd_count - fd0), 32'(1));

    // T4: flush with nothing collected
    base = log_data.size();
    fd0 = fd_count;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (6) step();
    chk(log_data.size() == base, "t4_no_word", 32'(log_data.size() - base), 32'(0));
    chk(fd_count == fd0 + 1, "t4_flush_done", 32'(fd_count - fd0), 32'(1));

    // T5: back-pressure with a full word held and more data waiting
    m_ready = 1'b0;
    base = log_data.size();
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
    c = 0;
    while (!m_valid && c < 20) begin step(); c++; end
    chk(m_valid == 1'b1, "t5_valid", 32'(m_valid), 32'(1));
    chk(m_data == 32'h14131211, "t5_held_data", m_data, 32'h14131211);
    snap = m_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk(m_valid && m_data == snap, "t5_stable", m_data, snap);
      chk(fifo_rd == 1'b0, "t5_no_pop", 32'(fifo_rd), 32'(0));
    end
    m_ready = 1'b1;
    wait_words(base + 2, 30, "t5_words");
    chk_word(base, 32'h14131211, 4'hF, 1'b0, "t5_w0");
    chk_word(base + 1, 32'h24232221, 4'hF, 1'b0, "t5_w1");
    repeat (3) step();

    // T6: flush coincides with the capture of the 4th byte
    base = log_data.size();
    fd0 = fd_count;
    p0 = pops;
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
    c = 0;
    while (pops < p0 + 4 && c < 20) begin step(); c++; end
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_words(base + 1, 20, "t6_word");
    repeat (8) step();
    chk_word(base, 32'h34333231, 4'hF, 1'b1, "t6");
    chk(log_data.size() == base + 1, "t6_no_extra", 32'(log_data.size() - base), 32'(1));
    chk(fd_count == fd0 + 1, "t6_flush_done", 32'(fd_count - fd0), 32'(1));

    // T1: reset with two lanes filled and a third byte in flight
    base = log_data.size();
    p0 = pops;
    for (int i = 0; i < 5; i++) push(8'h41 + 8'(i));
    c = 0;
    while (pops < p0 + 3 && c < 20) begin step(); c++; end
    reset = 1'b0;
    popped_q.delete();
    #1;
    chk(fifo_rd == 1'b0 && m_valid == 1'b0, "t1_rd_valid", 32'({fifo_rd, m_valid}), 32'(0));
    chk(m_data == 32'h0 && m_keep == 4'h0, "t1_data_keep", m_data, 32'h0);
    chk(m_last == 1'b0 && flush_done == 1'b0, "t1_last_fd", 32'({m_last, flush_done}), 32'(0));
    step();
    reset = 1'b1;
    push(8'h46); push(8'h47);
    wait_words(base + 1, 30, "t1_word");
    chk_word(base, 32'h47464544, 4'hF, 1'b0, "t1");
    repeat (3) step();

    // Random phase, then drain and flush out the remainder
    pb = pushed_bytes;
    eb = emitted_bytes;
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    flush = 1'b0;
    m_ready = 1'b1;
    c = 0;
    while (fifo_q.size() > 0 && c < 300) begin step(); c++; end
    chk(fifo_q.size() == 0, "drain_fifo", 32'(fifo_q.size()), 32'(0));
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (10) step();
    chk(emitted_bytes - eb == pushed_bytes - pb, "drain_byte_count",
        32'(emitted_bytes - eb), 32'(pushed_bytes - pb));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
